// File: rtl/day41_mux_stim_checker.sv
// LFSR-driven stimulus generator and response checker for a 2:1 mux (y = sel ? b : a).
// Optional first-mismatch capture outputs are enabled with `define DAY41_FIRST_ERR_EN.
module day41_mux_stim_checker #(
  parameter int          WIDTH   = 8,
  parameter int          NUM_TXN = 16,
  parameter logic [15:0] SEED    = 16'hACE1,
  localparam int         CW      = $clog2(NUM_TXN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             sel_o,
  input  logic [WIDTH-1:0] y_i,
  output logic [CW-1:0]    txn_cnt_o,
  output logic [CW-1:0]    err_cnt_o
`ifdef DAY41_FIRST_ERR_EN
  ,
  output logic [CW-1:0]    first_err_idx_o,
  output logic [WIDTH-1:0] first_err_exp_o,
  output logic [WIDTH-1:0] first_err_got_o
`endif
);

  // An all-zero seed would lock the LFSR up.
  localparam logic [15:0]   SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] TXN_LAST = CW'(NUM_TXN);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_CHECK, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       lfsr, lfsr_nxt;
  logic [WIDTH-1:0]  exp_y;
  logic              mism;
  logic [CW-1:0]     txn_inc, err_inc;

  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign exp_y    = sel_o ? b_o : a_o;
  assign mism     = (y_i != exp_y);
  assign txn_inc  = (txn_cnt_o == CNT_MAX) ? CNT_MAX : txn_cnt_o + CW'(1);
  assign err_inc  = (err_cnt_o == CNT_MAX) ? CNT_MAX : err_cnt_o + CW'(1);

  assign busy_o = (state == S_DRIVE) || (state == S_CHECK);
  assign done_o = (state == S_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_i) state_nxt = S_DRIVE;
      S_DRIVE: state_nxt = S_CHECK;
      S_CHECK: state_nxt = (txn_inc == TXN_LAST) ? S_DONE : S_DRIVE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stimulus and counters hold between runs; only an accepted start clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr      <= SEED_EFF;
      a_o       <= '0;
      b_o       <= '0;
      sel_o     <= 1'b0;
      txn_cnt_o <= '0;
      err_cnt_o <= '0;
      pass_o    <= 1'b0;
`ifdef DAY41_FIRST_ERR_EN
      first_err_idx_o <= '0;
      first_err_exp_o <= '0;
      first_err_got_o <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          lfsr      <= SEED_EFF;
          txn_cnt_o <= '0;
          err_cnt_o <= '0;
          pass_o    <= 1'b0;
`ifdef DAY41_FIRST_ERR_EN
          first_err_idx_o <= '0;
          first_err_exp_o <= '0;
          first_err_got_o <= '0;
`endif
        end
        S_DRIVE: begin
          a_o   <= lfsr[WIDTH-1:0];
          b_o   <= lfsr[15 -: WIDTH];
          sel_o <= lfsr[7];
          lfsr  <= lfsr_nxt;
        end
        S_CHECK: begin
          txn_cnt_o <= txn_inc;
          if (mism) begin
            err_cnt_o <= err_inc;
`ifdef DAY41_FIRST_ERR_EN
            if (err_cnt_o == '0) begin
              first_err_idx_o <= txn_cnt_o;
              first_err_exp_o <= exp_y;
              first_err_got_o <= y_i;
            end
`endif
          end
        end
        S_DONE: pass_o <= (err_cnt_o == '0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_day41_mux_stim_checker.sv
// Directed bench for day41_mux_stim_checker: ideal, stuck-zero, swapped and corrupted muxes on y_i.
module tb_day41_mux_stim_checker;
  localparam int WIDTH = 8;
  localparam int NUM_TXN = 16;
  localparam int CW = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start_i = 1'b0;
  logic             busy_o, done_o, pass_o, sel_o;
  logic [WIDTH-1:0] a_o, b_o, y_i;
  logic [CW-1:0]    txn_cnt_o, err_cnt_o;
`ifdef DAY41_FIRST_ERR_EN
  logic [CW-1:0]    first_err_idx_o;
  logic [WIDTH-1:0] first_err_exp_o, first_err_got_o;
`endif

  int checks = 0;
  int failures = 0;
  int mode = 0;

  logic [WIDTH-1:0] va [NUM_TXN];
  logic [WIDTH-1:0] vb [NUM_TXN];
  logic [WIDTH-1:0] vexp [NUM_TXN];
  logic             vs [NUM_TXN];
  int               nz_cnt, neq_cnt;

  day41_mux_stim_checker #(.WIDTH(WIDTH), .NUM_TXN(NUM_TXN), .SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .a_o(a_o), .b_o(b_o), .sel_o(sel_o), .y_i(y_i),
    .txn_cnt_o(txn_cnt_o), .err_cnt_o(err_cnt_o)
`ifdef DAY41_FIRST_ERR_EN
    , .first_err_idx_o(first_err_idx_o), .first_err_exp_o(first_err_exp_o),
    .first_err_got_o(first_err_got_o)
`endif
  );

  always #5 clk = ~clk;

  // Mux under test: 0 ideal, 1 stuck at zero, 2 a/b swapped, 3 ideal with bit 0 flipped at txn 3.
  always_comb begin
    y_i = sel_o ? b_o : a_o;
    case (mode)
      1: y_i = '0;
      2: y_i = sel_o ? a_o : b_o;
      3: if (txn_cnt_o == CW'(3)) y_i = (sel_o ? b_o : a_o) ^ WIDTH'(1);
      default: ;
    endcase
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Starts a run at the current negedge and follows it to IDLE; sampling is on negedges.
  task automatic run_chk(input string tag, input int exp_err, input bit exp_pass, input bit hold);
    int done_k;
    int i;
    done_k = -1;
    start_i = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (!hold) start_i = 1'b0;
        chk({tag, "_busy"}, 32'(busy_o), 32'd1);
        chk({tag, "_pass_clr"}, 32'(pass_o), 32'd0);
      end
      if (k == 1) begin
        chk({tag, "_hand_a0"}, 32'(a_o), 32'hE1);
        chk({tag, "_hand_b0"}, 32'(b_o), 32'hAC);
      end
      if (k == 3) begin
        chk({tag, "_hand_a1"}, 32'(a_o), 32'hC3);
        chk({tag, "_hand_b1"}, 32'(b_o), 32'h59);
      end
      if ((k % 2 == 1) && (k <= 2*NUM_TXN - 1)) begin
        i = (k - 1) / 2;
        chk($sformatf("%s_a%0d", tag, i), 32'(a_o), 32'(va[i]));
        chk($sformatf("%s_b%0d", tag, i), 32'(b_o), 32'(vb[i]));
        chk($sformatf("%s_s%0d", tag, i), 32'(sel_o), 32'(vs[i]));
      end
      if (done_o) begin
        done_k = k;
        break;
      end
    end
    chk({tag, "_done_lat"}, 32'(done_k), 32'(2*NUM_TXN));
    chk({tag, "_txn"}, 32'(txn_cnt_o), 32'(NUM_TXN));
    chk({tag, "_err"}, 32'(err_cnt_o), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
    chk({tag, "_pass"}, 32'(pass_o), 32'(exp_pass));
    chk({tag, "_txn_hold"}, 32'(txn_cnt_o), 32'(NUM_TXN));
  endtask

  initial begin
    logic [15:0] l;
    l = 16'hACE1;
    nz_cnt = 0;
    neq_cnt = 0;
    for (int i = 0; i < NUM_TXN; i++) begin
      va[i]   = l[WIDTH-1:0];
      vb[i]   = l[15 -: WIDTH];
      vs[i]   = l[7];
      vexp[i] = vs[i] ? vb[i] : va[i];
      if (vexp[i] != '0) nz_cnt++;
      if (va[i] != vb[i]) neq_cnt++;
      l = lfsr_step(l);
    end

    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_a", 32'(a_o), 32'd0);
    chk("rst_txn", 32'(txn_cnt_o), 32'd0);
    chk("rst_err", 32'(err_cnt_o), 32'd0);

    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'(busy_o), 32'd0);

    mode = 0; run_chk("ideal", 0, 1'b1, 1'b0);
    mode = 1; run_chk("zero", nz_cnt, (nz_cnt == 0), 1'b0);
    mode = 2; run_chk("swap", neq_cnt, (neq_cnt == 0), 1'b0);
    mode = 0;
    run_chk("hold1", 0, 1'b1, 1'b1);
    run_chk("hold2", 0, 1'b1, 1'b0);
    @(negedge clk);
    chk("hold_single_stop", 32'(busy_o), 32'd0);

    // Abort mid-run: reset asserted between clock edges during transaction 5.
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_txn5", 32'(txn_cnt_o), 32'd5);
    #1 reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_a", 32'(a_o), 32'd0);
    chk("arst_b", 32'(b_o), 32'd0);
    chk("arst_sel", 32'(sel_o), 32'd0);
    chk("arst_txn", 32'(txn_cnt_o), 32'd0);
    chk("arst_err", 32'(err_cnt_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_chk("post_rst", 0, 1'b1, 1'b0);

`ifdef DAY41_FIRST_ERR_EN
    mode = 3; run_chk("ferr", 1, 1'b0, 1'b0);
    chk("ferr_idx", 32'(first_err_idx_o), 32'd3);
    chk("ferr_exp", 32'(first_err_exp_o), 32'(vexp[3]));
    chk("ferr_got", 32'(first_err_got_o), 32'(vexp[3] ^ WIDTH'(1)));
    mode = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
